// File: rtl/mp_fifo_enq_arb.sv
// Round-robin enqueue arbiter packing up to ENQ_WIDTH producer requests onto FIFO lanes,
// plus flush sequencing. States: RUN | arbitrate, FLUSH | pulse flush, HOLD | block grants.
module mp_fifo_enq_arb #(
    parameter int NUM_REQ        = 6,
    parameter int ENQ_WIDTH      = 4,
    parameter int PAYLOAD_WIDTH  = 8,
    parameter int FLUSH_HOLD     = 2,
    parameter int WAIT_CNT_WIDTH = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REQ-1:0]                           req_vld_i,
    input  logic [NUM_REQ-1:0][PAYLOAD_WIDTH-1:0]        req_payload_i,
    output logic [NUM_REQ-1:0]                           req_rdy_o,
    output logic [ENQ_WIDTH-1:0]                         enq_vld_o,
    output logic [ENQ_WIDTH-1:0][PAYLOAD_WIDTH-1:0]      enq_payload_o,
    input  logic [ENQ_WIDTH-1:0]                         enq_rdy_i,
    input  logic                                         flush_req_i,
    output logic                                         fifo_flush_o,
    output logic                                         flush_busy_o,
    output logic [WAIT_CNT_WIDTH-1:0]                    max_wait_o
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LANE_W = $clog2(ENQ_WIDTH + 1);
    localparam int LIDX_W = (ENQ_WIDTH > 1) ? $clog2(ENQ_WIDTH) : 1;
    localparam int HOLD_W = $clog2(FLUSH_HOLD) + 1;

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HOLD} state_e;

    state_e                                   state_q, state_d;
    logic [PTR_W-1:0]                         ptr_q, ptr_d;
    logic [HOLD_W-1:0]                        hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0][WAIT_CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WAIT_CNT_WIDTH-1:0]                max_wait_q, max_wait_d;

    logic [ENQ_WIDTH-1:0]                     sel_vld;
    logic [ENQ_WIDTH-1:0][PAYLOAD_WIDTH-1:0]  sel_pay;
    logic [NUM_REQ-1:0]                       sel_gnt;
    logic                                     any_gnt;
    logic [PTR_W-1:0]                         ptr_after_gnt;
    logic [LANE_W-1:0]                        lane;
    logic [LIDX_W-1:0]                        lidx;
    logic [PTR_W:0]                           scan_sum;
    logic [PTR_W-1:0]                         idx;

    // Scan from ptr in wrap order; the k-th valid requester lands on lane k.
    always_comb begin
        sel_vld       = '0;
        sel_pay       = '0;
        sel_gnt       = '0;
        any_gnt       = 1'b0;
        ptr_after_gnt = ptr_q;
        lane          = '0;
        lidx          = '0;
        scan_sum      = '0;
        idx           = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = scan_sum[PTR_W-1:0];
            if (req_vld_i[idx] && (lane < LANE_W'(ENQ_WIDTH))) begin
                lidx          = lane[LIDX_W-1:0];
                sel_vld[lidx] = 1'b1;
                sel_pay[lidx] = req_payload_i[idx];
                if (enq_rdy_i[lidx]) begin
                    sel_gnt[idx]  = 1'b1;
                    any_gnt       = 1'b1;
                    ptr_after_gnt = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                end
                lane = lane + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        req_rdy_o     = '0;
        enq_vld_o     = '0;
        enq_payload_o = '0;
        fifo_flush_o  = 1'b0;
        flush_busy_o  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                req_rdy_o     = sel_gnt;
                enq_vld_o     = sel_vld;
                enq_payload_o = sel_pay;
                if (any_gnt) begin
                    ptr_d = ptr_after_gnt;
                end
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (req_vld_i[r] && !sel_gnt[r]) begin
                        if (wait_cnt_q[r] != '1) begin
                            wait_cnt_d[r] = wait_cnt_q[r] + 1'b1;
                        end
                    end else begin
                        wait_cnt_d[r] = '0;
                    end
                end
                if (flush_req_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                fifo_flush_o = 1'b1;
                flush_busy_o = 1'b1;
                ptr_d        = '0;
                wait_cnt_d   = '0;
                hold_cnt_d   = HOLD_W'(FLUSH_HOLD - 1);
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                flush_busy_o = 1'b1;
                if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Outputs must read idle while reset is held, whatever state we were in.
        if (rst) begin
            req_rdy_o     = '0;
            enq_vld_o     = '0;
            enq_payload_o = '0;
            fifo_flush_o  = 1'b0;
            flush_busy_o  = 1'b0;
        end
    end

    always_comb begin
        max_wait_d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (wait_cnt_q[r] > max_wait_d) begin
                max_wait_d = wait_cnt_q[r];
            end
        end
    end

    assign max_wait_o = rst ? '0 : max_wait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
            max_wait_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            max_wait_q <= max_wait_d;
        end
    end

endmodule

// File: tb/tb_mp_fifo_enq_arb.sv
// Scoreboard bench for mp_fifo_enq_arb: directed vectors then an all-or-none FIFO soak.
module tb_mp_fifo_enq_arb;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       req_vld = '0;
    logic [5:0][7:0]  req_pay;
    logic [5:0]       req_rdy;
    logic [3:0]       enq_vld;
    logic [3:0][7:0]  enq_pay;
    logic [3:0]       enq_rdy = '0;
    logic             flush_req = 1'b0;
    logic             fifo_flush;
    logic             flush_busy;
    logic [3:0]       max_wait;

    mp_fifo_enq_arb dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld_i     (req_vld),
        .req_payload_i (req_pay),
        .req_rdy_o     (req_rdy),
        .enq_vld_o     (enq_vld),
        .enq_payload_o (enq_pay),
        .enq_rdy_i     (enq_rdy),
        .flush_req_i   (flush_req),
        .fifo_flush_o  (fifo_flush),
        .flush_busy_o  (flush_busy),
        .max_wait_o    (max_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  rdy;
        logic [3:0]  vld;
        logic [31:0] pay;
        logic        fl;
        logic        bz;
        logic [3:0]  mw;
        bit          rnd;
        int          mw_bound;
        int          id;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pay_q[3][$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         vec_id  = 0;

    function automatic void check(string nm, int id, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
        end
    endfunction

    task automatic step(input logic r, input logic [5:0] v, input logic [3:0] er, input logic f,
                        input logic [5:0] x_rdy, input logic [3:0] x_vld, input logic [31:0] x_pay,
                        input logic x_fl, input logic x_bz, input logic [3:0] x_mw);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; req_vld = v; enq_rdy = er; flush_req = f;
        e.rdy = x_rdy; e.vld = x_vld; e.pay = x_pay; e.fl = x_fl; e.bz = x_bz; e.mw = x_mw;
        e.rnd = 1'b0; e.mw_bound = 0; e.id = vec_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation for every cycle the driver presented stimulus.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("req_rdy", e.id, 32'(req_rdy), 32'(e.rdy));
            check("enq_vld", e.id, 32'(enq_vld), 32'(e.vld));
            if (!e.rnd) begin
                check("enq_payload", e.id, enq_pay, e.pay);
                check("fifo_flush", e.id, 32'(fifo_flush), 32'(e.fl));
                check("flush_busy", e.id, 32'(flush_busy), 32'(e.bz));
                check("max_wait", e.id, 32'(max_wait), 32'(e.mw));
            end else begin
                logic [3:0] v1;
                v1 = enq_vld + 4'd1;
                check("lane_prefix", e.id, 32'(enq_vld & v1), 32'd0);
                n_tests++;
                if (int'(max_wait) > e.mw_bound) begin
                    n_fail++;
                    $display("FAIL max_wait_bound vec%0d: got %0d limit %0d", e.id, max_wait, e.mw_bound);
                end
                for (int k = 0; k < 4; k++) begin
                    if (enq_vld[k] && enq_rdy[k]) begin
                        int rq;
                        rq = int'(enq_pay[k][7:6]);
                        if (rq > 2 || pay_q[rq].size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_payload vec%0d: got %h on lane %0d expected none", e.id, enq_pay[k], k);
                        end else begin
                            check("payload_order", e.id, 32'(enq_pay[k]), 32'(pay_q[rq].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [5:0] seq[3];
        logic [3:0] er;
        exp_t       e;
        int         streak, max_streak, guard;
        for (int r = 0; r < 6; r++) req_pay[r] = 8'(8'hA0 + r);

        // reset, then all valid / all ready: two rounds of round-robin
        step(1, 6'h3F, 4'hF, 0, 6'h00, 4'h0, 32'h0,        0, 0, 4'd0);
        step(1, 6'h3F, 4'hF, 0, 6'h00, 4'h0, 32'h0,        0, 0, 4'd0);
        step(0, 6'h3F, 4'hF, 0, 6'h0F, 4'hF, 32'hA3A2A1A0, 0, 0, 4'd0);
        step(0, 6'h3F, 4'hF, 0, 6'h33, 4'hF, 32'hA1A0A5A4, 0, 0, 4'd0);
        step(0, 6'h00, 4'hF, 0, 6'h00, 4'h0, 32'h0,        0, 0, 4'd1);
        // sparse requesters, partial prefix ready
        step(1, 6'h00, 4'hF, 0, 6'h00, 4'h0, 32'h0,        0, 0, 4'd0);
        step(0, 6'h2A, 4'h3, 0, 6'h0A, 4'h7, 32'h00A5A3A1, 0, 0, 4'd0);
        step(0, 6'h2A, 4'h3, 0, 6'h22, 4'h7, 32'h00A3A1A5, 0, 0, 4'd0);
        // FIFO full for five cycles with req2 waiting
        step(0, 6'h04, 4'h0, 0, 6'h00, 4'h1, 32'h000000A2, 0, 0, 4'd1);
        step(0, 6'h04, 4'h0, 0, 6'h00, 4'h1, 32'h000000A2, 0, 0, 4'd1);
        step(0, 6'h04, 4'h0, 0, 6'h00, 4'h1, 32'h000000A2, 0, 0, 4'd1);
        step(0, 6'h04, 4'h0, 0, 6'h00, 4'h1, 32'h000000A2, 0, 0, 4'd2);
        step(0, 6'h04, 4'h0, 0, 6'h00, 4'h1, 32'h000000A2, 0, 0, 4'd3);
        step(0, 6'h04, 4'h1, 0, 6'h04, 4'h1, 32'h000000A2, 0, 0, 4'd4);
        step(0, 6'h00, 4'hF, 0, 6'h00, 4'h0, 32'h0,        0, 0, 4'd5);
        step(0, 6'h00, 4'hF, 0, 6'h00, 4'h0, 32'h0,        0, 0, 4'd0);
        // flush: grants in the request cycle, then 3 busy cycles; request during HOLD ignored
        step(0, 6'h3F, 4'hF, 1, 6'h39, 4'hF, 32'hA0A5A4A3, 0, 0, 4'd0);
        step(0, 6'h3F, 4'hF, 0, 6'h00, 4'h0, 32'h0,        1, 1, 4'd0);
        step(0, 6'h3F, 4'hF, 1, 6'h00, 4'h0, 32'h0,        0, 1, 4'd1);
        step(0, 6'h3F, 4'hF, 0, 6'h00, 4'h0, 32'h0,        0, 1, 4'd0);
        step(0, 6'h3F, 4'hF, 0, 6'h0F, 4'hF, 32'hA3A2A1A0, 0, 0, 4'd0);
        step(0, 6'h3F, 4'hF, 0, 6'h33, 4'hF, 32'hA1A0A5A4, 0, 0, 4'd0);
        // reset during HOLD
        step(0, 6'h00, 4'hF, 1, 6'h00, 4'h0, 32'h0,        0, 0, 4'd1);
        step(0, 6'h00, 4'hF, 0, 6'h00, 4'h0, 32'h0,        1, 1, 4'd1);
        step(1, 6'h00, 4'hF, 0, 6'h00, 4'h0, 32'h0,        0, 0, 4'd0);
        step(0, 6'h3F, 4'hF, 0, 6'h0F, 4'hF, 32'hA3A2A1A0, 0, 0, 4'd0);
        step(1, 6'h00, 4'h0, 0, 6'h00, 4'h0, 32'h0,        0, 0, 4'd0);

        // all-or-none FIFO soak, requesters 0..2 always valid
        for (int r = 0; r < 3; r++) seq[r] = 6'(r * 5);
        streak = 0; max_streak = 0;
        for (int c = 0; c < 200; c++) begin
            er = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
            @(posedge clk);
            #1;
            rst = 1'b0; flush_req = 1'b0; req_vld = 6'h07; enq_rdy = er;
            for (int r = 0; r < 3; r++) begin
                logic [7:0] p;
                p = {2'(r), seq[r]};
                if (req_pay[r] !== p || c == 0) pay_q[r].push_back(p);
                req_pay[r] = p;
            end
            if (er == 4'h0) streak++; else streak = 0;
            if (streak > max_streak) max_streak = streak;
            e.rdy = (er == 4'hF) ? 6'h07 : 6'h00; e.vld = 4'h7; e.pay = '0;
            e.fl = 1'b0; e.bz = 1'b0; e.mw = '0; e.rnd = 1'b1;
            e.mw_bound = max_streak + 1; e.id = vec_id++;
            exp_q.push_back(e);
            if (er == 4'hF) begin
                for (int r = 0; r < 3; r++) seq[r] = seq[r] + 6'd1;
            end
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        n_tests++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        for (int r = 0; r < 3; r++) begin
            n_tests++;
            if (pay_q[r].size() > 1) begin
                n_fail++;
                $display("FAIL payload_dropped req%0d: got %0d ungranted expected at most 1", r, pay_q[r].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
